// File: rtl/accumulate_array.sv
// accumulate_array: LANES independent signed accumulators fed through a valid/ready term
// input, with a held valid/ready result and per-lane saturating or wrapping overflow.
module accumulate_array #(
   parameter int LANES     = 4,
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 32,
   parameter int LEN_WIDTH = 8,
   parameter bit SATURATE  = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [LEN_WIDTH-1:0]       len,
   input  logic [LANES*ACC_WIDTH-1:0] init_val,
   input  logic [LANES*IN_WIDTH-1:0]  din,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [LANES*ACC_WIDTH-1:0] acc_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES-1:0]           sat_flag,
   output logic                       busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]                 state;
   logic [LEN_WIDTH-1:0]       cnt;
   logic [LANES*ACC_WIDTH-1:0] acc;
   logic [LANES*ACC_WIDTH-1:0] acc_next;
   logic [LANES-1:0]           sat;
   logic [LANES-1:0]           lane_ovf;
   logic                       start_accept;

   // A DONE result may be drained and a new run started on the same edge.
   assign start_accept = start && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));

   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign acc_out   = acc;
   assign sat_flag  = sat;

   // Sum is formed one bit wider so a sign disagreement in the top two bits flags overflow.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [ACC_WIDTH-1:0] cur;
      logic [IN_WIDTH-1:0]  term;
      logic [ACC_WIDTH:0]   sum;
      logic                 ovf;

      assign cur  = acc[i*ACC_WIDTH +: ACC_WIDTH];
      assign term = din[i*IN_WIDTH +: IN_WIDTH];
      assign sum  = {cur[ACC_WIDTH-1], cur}
                  + {{(ACC_WIDTH+1-IN_WIDTH){term[IN_WIDTH-1]}}, term};
      assign ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      assign lane_ovf[i] = ovf;
      assign acc_next[i*ACC_WIDTH +: ACC_WIDTH] =
         (ovf && (SATURATE == 1'b1))
            ? (sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}})
            : sum[ACC_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         acc   <= '0;
         cnt   <= '0;
         sat   <= '0;
      end else if (start_accept) begin
         acc   <= init_val;
         cnt   <= len;
         sat   <= '0;
         state <= (len == '0) ? ST_DONE : ST_ACCUM;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (in_valid) begin
                  acc <= acc_next;
                  cnt <= cnt - LEN_WIDTH'(1);
                  sat <= sat | lane_ovf;
                  if (cnt == LEN_WIDTH'(1)) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
